// File: rtl/spi_slave_if.sv
// SPI pins plus the byte-level transmit/receive handshake of spi_slave.
// The slave modport is the design side; the master modport drives it from outside.
interface spi_slave_if;
    logic       spi_clk_i;
    logic       spi_ss_i;
    logic       spi_mosi_i;
    logic       spi_miso_o;
    logic       spi_miso_oe_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       tx_underrun_o;
    logic       busy_o;

    modport slave (
        input  spi_clk_i, spi_ss_i, spi_mosi_i, tx_data_i, tx_valid_i,
        output spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
        output tx_underrun_o, busy_o
    );

    modport master (
        output spi_clk_i, spi_ss_i, spi_mosi_i, tx_data_i, tx_valid_i,
        input  spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
        input  tx_underrun_o, busy_o
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave oversampled in clk_i: synchronised pins, MSB-first byte shifting, one-byte tx holding buffer.
// rx_valid_o follows the 8th sample edge by 3 clk_i cycles; receive has no backpressure, transmit underruns send 0x00.
module spi_slave #(
    parameter bit CPOL           = 1'b0,
    parameter bit CPHA           = 1'b0,
    parameter bit SS_ACTIVE_HIGH = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    spi_slave_if.slave bus
);
    localparam bit SS_IDLE = !SS_ACTIVE_HIGH;

    logic [1:0] sclk_sync_q, sclk_sync_d;
    logic [1:0] ss_sync_q, ss_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic       sel_q, sel_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] hold_q, hold_d;
    logic       full_q, full_d;
    logic       underrun_q, underrun_d;

    logic sel, sclk_edge, lead_evt, trail_evt, sample_evt, shift_evt, load_evt;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[0], bus.spi_clk_i};
        ss_sync_d   = {ss_sync_q[0], bus.spi_ss_i};
        mosi_sync_d = {mosi_sync_q[0], bus.spi_mosi_i};
        sclk_prev_d = sclk_sync_q[1];

        sel        = (ss_sync_q[1] == SS_ACTIVE_HIGH);
        sel_d      = sel;
        sclk_edge  = (sclk_sync_q[1] != sclk_prev_q);
        lead_evt   = sclk_edge && (sclk_prev_q == CPOL);
        trail_evt  = sclk_edge && (sclk_prev_q != CPOL);
        sample_evt = sel && (CPHA ? trail_evt : lead_evt);
        shift_evt  = sel && (CPHA ? lead_evt : trail_evt);
        // With the counter at 0 a shift edge always starts a new byte; CPHA=0 also needs the first byte ready at select.
        load_evt   = (shift_evt && (bit_cnt_q == 3'd0)) || (!CPHA && sel && !sel_q);

        bit_cnt_d  = bit_cnt_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_sh_d    = tx_sh_q;
        hold_d     = hold_q;
        full_d     = full_q;
        underrun_d = 1'b0;

        if (!sel) begin
            bit_cnt_d = 3'd0;
            rx_sh_d   = 8'h00;
            tx_sh_d   = 8'h00;
        end else begin
            if (sample_evt) begin
                rx_sh_d   = {rx_sh_q[6:0], mosi_sync_q[1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_data_d  = rx_sh_d;
                    rx_valid_d = 1'b1;
                end
            end
            if (load_evt) begin
                if (full_q) begin
                    tx_sh_d = hold_q;
                    full_d  = 1'b0;
                end else begin
                    tx_sh_d    = 8'h00;
                    underrun_d = 1'b1;
                end
            end else if (shift_evt) begin
                tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
        end

        // Accepting only while empty keeps a same-cycle underrun load from taking this byte.
        if (bus.tx_valid_i && !full_q) begin
            hold_d = bus.tx_data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync_q <= {2{CPOL}};
            ss_sync_q   <= {2{SS_IDLE}};
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= CPOL;
            sel_q       <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_sh_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_sh_q     <= 8'h00;
            hold_q      <= 8'h00;
            full_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            sel_q       <= sel_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.spi_miso_o    = sel_q & tx_sh_q[7];
    assign bus.spi_miso_oe_o = sel_q;
    assign bus.busy_o        = sel_q;
    assign bus.tx_ready_o    = !full_q;
    assign bus.rx_data_o     = rx_data_q;
    assign bus.rx_valid_o    = rx_valid_q;
    assign bus.tx_underrun_o = underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave in mode 0 (u_dut0) and mode 3 (u_dut1) with a received-byte scoreboard.
module tb_spi_slave;
    localparam int H = 60;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if if0();
    spi_slave_if if1();

    spi_slave #(.CPOL(1'b0), .CPHA(1'b0), .SS_ACTIVE_HIGH(1'b0)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
    spi_slave #(.CPOL(1'b1), .CPHA(1'b1), .SS_ACTIVE_HIGH(1'b0)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

    int n_cmp = 0;
    int n_bad = 0;
    int rxv0 = 0, rxv1 = 0, und0 = 0, und1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drv_clk(input int d, input logic v);
        if (d == 0) if0.spi_clk_i = v; else if1.spi_clk_i = v;
    endtask
    task automatic drv_ss(input int d, input logic v);
        if (d == 0) if0.spi_ss_i = v; else if1.spi_ss_i = v;
    endtask
    task automatic drv_mosi(input int d, input logic v);
        if (d == 0) if0.spi_mosi_i = v; else if1.spi_mosi_i = v;
    endtask
    task automatic drv_tx(input int d, input logic v, input logic [7:0] b);
        if (d == 0) begin if0.tx_valid_i = v; if0.tx_data_i = b; end
        else begin if1.tx_valid_i = v; if1.tx_data_i = b; end
    endtask
    function automatic logic get_miso(input int d);
        return (d == 0) ? if0.spi_miso_o : if1.spi_miso_o;
    endfunction
    function automatic logic get_ready(input int d);
        return (d == 0) ? if0.tx_ready_o : if1.tx_ready_o;
    endfunction

    // Master side: nbits bits MSB first from mo[nbits-1:0]; mi collects MISO at the master's sample edges.
    task automatic frame(input int d, input int nbits, input logic [15:0] mo, output logic [15:0] mi);
        logic cpol;
        logic cpha;
        cpol = (d == 1);
        cpha = (d == 1);
        mi = 16'h0000;
        @(negedge clk);
        drv_ss(d, 1'b0);
        #100;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                drv_mosi(d, mo[i]);
                #H;
                drv_clk(d, !cpol);
                mi[i] = get_miso(d);
                #H;
                drv_clk(d, cpol);
            end else begin
                drv_clk(d, !cpol);
                drv_mosi(d, mo[i]);
                #H;
                drv_clk(d, cpol);
                mi[i] = get_miso(d);
                #H;
            end
        end
        #H;
        drv_ss(d, 1'b1);
        #200;
    endtask

    task automatic load(input int d, input logic [7:0] b);
        @(negedge clk);
        check($sformatf("tx_ready_before_load%0d", d), get_ready(d), 1'b1);
        drv_tx(d, 1'b1, b);
        @(negedge clk);
        drv_tx(d, 1'b0, 8'h00);
        check($sformatf("tx_ready_after_load%0d", d), get_ready(d), 1'b0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_miso0"}, if0.spi_miso_o, 1'b0);
        check({tag, "_oe0"}, if0.spi_miso_oe_o, 1'b0);
        check({tag, "_ready0"}, if0.tx_ready_o, 1'b1);
        check({tag, "_rxdata0"}, if0.rx_data_o, 8'h00);
        check({tag, "_rxvalid0"}, if0.rx_valid_o, 1'b0);
        check({tag, "_underrun0"}, if0.tx_underrun_o, 1'b0);
        check({tag, "_busy0"}, if0.busy_o, 1'b0);
        check({tag, "_miso1"}, if1.spi_miso_o, 1'b0);
        check({tag, "_oe1"}, if1.spi_miso_oe_o, 1'b0);
        check({tag, "_ready1"}, if1.tx_ready_o, 1'b1);
        check({tag, "_rxdata1"}, if1.rx_data_o, 8'h00);
        check({tag, "_busy1"}, if1.busy_o, 1'b0);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (if0.rx_valid_o) begin
                rxv0++;
                if (q0.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rx0_unexpected: got 0x%0h, expected no rx_valid_o", if0.rx_data_o);
                end else check("rx0_data", if0.rx_data_o, q0.pop_front());
            end
            if (if1.rx_valid_o) begin
                rxv1++;
                if (q1.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rx1_unexpected: got 0x%0h, expected no rx_valid_o", if1.rx_data_o);
                end else check("rx1_data", if1.rx_data_o, q1.pop_front());
            end
            if (if0.tx_underrun_o) und0++;
            if (if1.tx_underrun_o) und1++;
        end
    endtask

    initial begin
        logic [15:0] mi;
        int base;
        int n;

        if0.spi_clk_i = 1'b0; if0.spi_ss_i = 1'b1; if0.spi_mosi_i = 1'b0;
        if0.tx_valid_i = 1'b0; if0.tx_data_i = 8'h00;
        if1.spi_clk_i = 1'b1; if1.spi_ss_i = 1'b1; if1.spi_mosi_i = 1'b0;
        if1.tx_valid_i = 1'b0; if1.tx_data_i = 8'h00;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        fork monitor(); join_none
        repeat (5) @(negedge clk);

        // Mode 0 single byte exchange.
        load(0, 8'hA5);
        q0.push_back(8'h3C);
        base = rxv0;
        fork
            frame(0, 8, 16'h003C, mi);
            begin
                #150;
                check("busy_in_frame", if0.busy_o, 1'b1);
                check("oe_in_frame", if0.spi_miso_oe_o, 1'b1);
                check("miso_first_bit", if0.spi_miso_o, 1'b1);
            end
        join
        check("m0_master_rx", mi[7:0], 8'hA5);
        check("m0_rx_pulses", rxv0 - base, 1);
        check("m0_rx_data", if0.rx_data_o, 8'h3C);
        check("m0_ready_back", if0.tx_ready_o, 1'b1);
        check("m0_busy_after", if0.busy_o, 1'b0);

        // Abort after 5 bits while a byte arrives in the holding register mid-frame.
        base = rxv0;
        fork
            frame(0, 5, 16'h001F, mi);
            begin #300; load(0, 8'h77); end
        join
        check("abort_no_rx", rxv0 - base, 0);
        check("abort_rx_held", if0.rx_data_o, 8'h3C);
        q0.push_back(8'hC3);
        frame(0, 8, 16'h00C3, mi);
        check("after_abort_holding_kept", mi[7:0], 8'h77);
        check("after_abort_rx", if0.rx_data_o, 8'hC3);

        // Second byte offered while full; it must land one cycle after the held byte moves out.
        load(0, 8'h11);
        @(negedge clk);
        drv_tx(0, 1'b1, 8'h22);
        repeat (3) @(negedge clk);
        check("ready_while_full", if0.tx_ready_o, 1'b0);
        q0.push_back(8'h00);
        q0.push_back(8'h00);
        fork
            frame(0, 16, 16'h0000, mi);
            begin
                n = 0;
                while (!if0.tx_ready_o && n < 2000) begin @(negedge clk); n++; end
                check("ready_rises", if0.tx_ready_o, 1'b1);
                check("ready_with_select", if0.busy_o, 1'b1);
                @(negedge clk);
                drv_tx(0, 1'b0, 8'h00);
                check("second_byte_taken", if0.tx_ready_o, 1'b0);
            end
        join
        check("two_bytes_miso", mi, 16'h1122);

        // Mode 3: two-byte frame with one byte loaded underruns once.
        load(1, 8'h5A);
        q1.push_back(8'h01);
        q1.push_back(8'h02);
        base = und1;
        frame(1, 16, 16'h0102, mi);
        check("m3_underrun_miso", mi, 16'h5A00);
        check("m3_underrun_count", und1 - base, 1);
        check("m3_ready_idle", if1.tx_ready_o, 1'b1);

        load(1, 8'h81);
        q1.push_back(8'h81);
        frame(1, 8, 16'h0081, mi);
        check("m3_master_rx", mi[7:0], 8'h81);
        check("m3_rx_data", if1.rx_data_o, 8'h81);

        // Reset mid-byte with a byte held; outputs must drop before the next clk_i edge.
        load(0, 8'h99);
        fork
            frame(0, 8, 16'h00FF, mi);
            begin
                #470;
                check("pre_reset_busy", if0.busy_o, 1'b1);
                #3 rst = 1'b1;
                #1 check_reset("midreset");
            end
        join
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_ready", if0.tx_ready_o, 1'b1);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
